// File: rtl/pc_unit_ras_pkg.sv
// Shared definitions for the program-counter unit with return-address stack:
// pc_sel encodings, the default reset vector and the stack pointer-width helper.
package pc_unit_ras_pkg;

  typedef enum logic [2:0] {
    PC_SEL_INC  = 3'b000,
    PC_SEL_BUS  = 3'b001,
    PC_SEL_EA   = 3'b010,
    PC_SEL_CALL = 3'b011,
    PC_SEL_RET  = 3'b100
  } pc_sel_e;

  localparam int DEFAULT_RESET_PC = 0;

  // Bits needed to index a stack of the given (power-of-two) depth.
  function automatic int rasPtrWidth(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/pc_unit_ras_if.sv
// Control/status bundle of pc_unit_ras. The tri-state pc/pc_minus_one bus
// drivers stay plain module ports so they can share a resolved net.
// Optional macro PC_UNIT_PREV_EN adds the prev_pc trace output.
interface pc_unit_ras_if #(
  parameter int AW = 16,
  parameter int DW = 3
);
  logic [AW-1:0] bus;
  logic [AW-1:0] ea;
  logic          ld_pc;
  logic [2:0]    pc_sel;
  logic          stall;
  logic          clr_err;
  logic          gate_pc_en;
  logic          gate_pc_minus_1_en;
  logic [AW-1:0] reg_pc;
  logic [DW-1:0] ras_depth;
  logic          ras_ovf;
  logic          ras_unf;
`ifdef PC_UNIT_PREV_EN
  logic [AW-1:0] prev_pc;

  modport slave (
    input  bus, ea, ld_pc, pc_sel, stall, clr_err, gate_pc_en, gate_pc_minus_1_en,
    output reg_pc, ras_depth, ras_ovf, ras_unf, prev_pc
  );
  modport master (
    output bus, ea, ld_pc, pc_sel, stall, clr_err, gate_pc_en, gate_pc_minus_1_en,
    input  reg_pc, ras_depth, ras_ovf, ras_unf, prev_pc
  );
`else
  modport slave (
    input  bus, ea, ld_pc, pc_sel, stall, clr_err, gate_pc_en, gate_pc_minus_1_en,
    output reg_pc, ras_depth, ras_ovf, ras_unf
  );
  modport master (
    output bus, ea, ld_pc, pc_sel, stall, clr_err, gate_pc_en, gate_pc_minus_1_en,
    input  reg_pc, ras_depth, ras_ovf, ras_unf
  );
`endif
endinterface

// File: rtl/pc_unit_ras_stack.sv
// Circular return-address stack: a push while full overwrites the oldest
// entry; a pop while empty is ignored (the caller flags it).
module pc_ras_stack
  import pc_unit_ras_pkg::*;
#(
  parameter int AW    = 16,
  parameter int DEPTH = 4,
  localparam int PW   = rasPtrWidth(DEPTH),
  localparam int DW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [AW-1:0] push_data,
  input  logic          pop,
  output logic [AW-1:0] top,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] depth
);

  logic [AW-1:0] mem_q [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [DW-1:0] depth_q, depth_d;

  assign full  = (depth_q == DW'(DEPTH));
  assign empty = (depth_q == '0);
  assign top   = mem_q[ptr_q - PW'(1)];
  assign depth = depth_q;

  // Pointer and occupancy next state; a full push keeps depth saturated.
  always_comb begin
    ptr_d   = ptr_q;
    depth_d = depth_q;
    if (push) begin
      ptr_d = ptr_q + PW'(1);
      if (!full) depth_d = depth_q + DW'(1);
    end else if (pop && !empty) begin
      ptr_d   = ptr_q - PW'(1);
      depth_d = depth_q - DW'(1);
    end
  end

  // Pointer and depth registers, cleared on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      depth_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      depth_q <= depth_d;
    end
  end

  // Entry storage; contents after reset are irrelevant so it has no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[ptr_q] <= push_data;
  end

endmodule

// File: rtl/pc_unit_ras.sv
// Program-counter unit with load modes, stall, call/return stack, sticky
// stack error flags and tri-state bus gates for PC and PC-1.
// Optional macro PC_UNIT_PREV_EN adds prev_pc (old PC captured on every update).
module pc_unit_ras
  import pc_unit_ras_pkg::*;
#(
  parameter int              AW        = 16,
  parameter logic [AW-1:0]   RESET_PC  = AW'(DEFAULT_RESET_PC),
  parameter int              INC_STEP  = 1,
  parameter int              RAS_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  pc_unit_ras_if.slave   pcIf,
  output wire [AW-1:0]   pc,
  output wire [AW-1:0]   pc_minus_one
);

  localparam int DW = $clog2(RAS_DEPTH) + 1;

  logic [AW-1:0] regPc_q, regPc_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          upd, doPush, doPop;
  logic [AW-1:0] pcInc;
  logic [AW-1:0] rasTop;
  logic          rasFull, rasEmpty;
  logic [DW-1:0] rasDepth;

  assign upd    = pcIf.ld_pc & ~pcIf.stall;
  assign pcInc  = regPc_q + AW'(INC_STEP);
  assign doPush = upd && (pcIf.pc_sel == PC_SEL_CALL);
  assign doPop  = upd && (pcIf.pc_sel == PC_SEL_RET);

  pc_ras_stack #(
    .AW    (AW),
    .DEPTH (RAS_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (doPush),
    .push_data (pcInc),
    .pop       (doPop),
    .top       (rasTop),
    .full      (rasFull),
    .empty     (rasEmpty),
    .depth     (rasDepth)
  );

  // PC source mux and sticky flag next state; a new error beats clr_err.
  always_comb begin
    regPc_d = regPc_q;
    ovf_d   = pcIf.clr_err ? 1'b0 : ovf_q;
    unf_d   = pcIf.clr_err ? 1'b0 : unf_q;
    if (upd) begin
      case (pcIf.pc_sel)
        PC_SEL_INC:  regPc_d = pcInc;
        PC_SEL_BUS:  regPc_d = pcIf.bus;
        PC_SEL_EA:   regPc_d = pcIf.ea;
        PC_SEL_CALL: begin
          regPc_d = pcIf.ea;
          if (rasFull) ovf_d = 1'b1;
        end
        PC_SEL_RET: begin
          if (rasEmpty) unf_d = 1'b1;
          else          regPc_d = rasTop;
        end
        default: regPc_d = regPc_q;
      endcase
    end
  end

  // PC and flag registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regPc_q <= RESET_PC;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      regPc_q <= regPc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

`ifdef PC_UNIT_PREV_EN
  logic [AW-1:0] prevPc_q;

  // Trace register: old PC captured on any non-hold update, including ret on empty.
  always_ff @(posedge clk) begin
    if (!rst_n)
      prevPc_q <= RESET_PC;
    else if (upd && (pcIf.pc_sel <= PC_SEL_RET))
      prevPc_q <= regPc_q;
  end

  assign pcIf.prev_pc = prevPc_q;
`endif

  assign pcIf.reg_pc    = regPc_q;
  assign pcIf.ras_depth = rasDepth;
  assign pcIf.ras_ovf   = ovf_q;
  assign pcIf.ras_unf   = unf_q;

  assign pc           = pcIf.gate_pc_en         ? regPc_q           : 'z;
  assign pc_minus_one = pcIf.gate_pc_minus_1_en ? regPc_q - AW'(1)  : 'z;

endmodule

// File: tb/tb_pc_unit_ras.sv
// Directed self-checking bench for pc_unit_ras (AW=16, RESET_PC=3000h, depth 4).
// pc and pc_minus_one share one resolved net with a bench driver, so a
// released gate is observed as the bench's own value winning the net.
module tb_pc_unit_ras;
  import pc_unit_ras_pkg::*;

  localparam int          AW  = 16;
  localparam int          DW  = 3;
  localparam logic [15:0] RPC = 16'h3000;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic        tbDrvEn;
  logic [15:0] tbDrvVal;
  wire  [15:0] busNet;

  pc_unit_ras_if #(.AW(AW), .DW(DW)) pIf ();

  assign busNet = tbDrvEn ? tbDrvVal : 'z;

  pc_unit_ras #(
    .AW        (AW),
    .RESET_PC  (RPC),
    .INC_STEP  (1),
    .RAS_DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pcIf         (pIf),
    .pc           (busNet),
    .pc_minus_one (busNet)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs, then sample point is #1 after the rising edge.
  task automatic applyStimulus(input logic ld, input logic [2:0] sel, input logic stl,
                               input logic clr, input logic [15:0] busV, input logic [15:0] eaV);
    pIf.ld_pc   = ld;
    pIf.pc_sel  = sel;
    pIf.stall   = stl;
    pIf.clr_err = clr;
    pIf.bus     = busV;
    pIf.ea      = eaV;
    @(posedge clk);
    #1;
    pIf.ld_pc   = 1'b0;
    pIf.clr_err = 1'b0;
    pIf.stall   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    applyStimulus(1'b1, PC_SEL_CALL, 1'b0, 1'b0, 16'h0, 16'h1234);
    applyStimulus(1'b0, PC_SEL_INC, 1'b0, 1'b0, 16'h0, 16'h0);
    rst_n = 1'b1;
    checks++;
    if (pIf.reg_pc !== RPC) begin errors++; $display("[TB] FAIL reset_pc actual=%h required=%h", pIf.reg_pc, RPC); end
    checks++;
    if (pIf.ras_depth !== 3'd0) begin errors++; $display("[TB] FAIL reset_depth actual=%0d required=0", pIf.ras_depth); end
    checks++;
    if ({pIf.ras_ovf, pIf.ras_unf} !== 2'b00) begin errors++; $display("[TB] FAIL reset_flags actual=%b required=00", {pIf.ras_ovf, pIf.ras_unf}); end
  endtask

  task automatic test_inc();
    logic [15:0] exp;
    exp = 16'h3000;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, PC_SEL_INC, 1'b0, 1'b0, 16'h0, 16'h0);
      exp = exp + 16'h1;
      checks++;
      if (pIf.reg_pc !== exp) begin errors++; $display("[TB] FAIL inc_%0d actual=%h required=%h", i, pIf.reg_pc, exp); end
    end
    tbDrvEn = 1'b1; tbDrvVal = 16'hA5A5;
    #1;
    checks++;
    if (busNet !== 16'hA5A5) begin errors++; $display("[TB] FAIL gates_off_hiz actual=%h required=a5a5", busNet); end
    tbDrvEn = 1'b0; pIf.gate_pc_en = 1'b1;
    #1;
    checks++;
    if (busNet !== 16'h3003) begin errors++; $display("[TB] FAIL gate_pc actual=%h required=3003", busNet); end
    pIf.gate_pc_en = 1'b0; pIf.gate_pc_minus_1_en = 1'b1;
    #1;
    checks++;
    if (busNet !== 16'h3002) begin errors++; $display("[TB] FAIL gate_pc_minus_one actual=%h required=3002", busNet); end
    pIf.gate_pc_minus_1_en = 1'b0; tbDrvEn = 1'b1; tbDrvVal = 16'h5A5A;
    #1;
    checks++;
    if (busNet !== 16'h5A5A) begin errors++; $display("[TB] FAIL gates_released actual=%h required=5a5a", busNet); end
    tbDrvEn = 1'b0;
  endtask

  task automatic test_wrap();
    applyStimulus(1'b1, PC_SEL_BUS, 1'b0, 1'b0, 16'hFFFF, 16'h0);
    checks++;
    if (pIf.reg_pc !== 16'hFFFF) begin errors++; $display("[TB] FAIL bus_load actual=%h required=ffff", pIf.reg_pc); end
    applyStimulus(1'b1, PC_SEL_INC, 1'b0, 1'b0, 16'h0, 16'h0);
    checks++;
    if (pIf.reg_pc !== 16'h0000) begin errors++; $display("[TB] FAIL inc_wrap actual=%h required=0000", pIf.reg_pc); end
    pIf.gate_pc_minus_1_en = 1'b1;
    #1;
    checks++;
    if (busNet !== 16'hFFFF) begin errors++; $display("[TB] FAIL pcm1_wrap actual=%h required=ffff", busNet); end
    pIf.gate_pc_minus_1_en = 1'b0;
    applyStimulus(1'b1, PC_SEL_EA, 1'b0, 1'b0, 16'h1111, 16'h2468);
    checks++;
    if (pIf.reg_pc !== 16'h2468) begin errors++; $display("[TB] FAIL ea_load actual=%h required=2468", pIf.reg_pc); end
    applyStimulus(1'b1, 3'b101, 1'b0, 1'b0, 16'h1111, 16'h9999);
    checks++;
    if (pIf.reg_pc !== 16'h2468) begin errors++; $display("[TB] FAIL reserved_hold actual=%h required=2468", pIf.reg_pc); end
  endtask

  task automatic test_call_ret();
    logic [15:0] expPc [4];
    logic [2:0]  expDp [4];
    logic [2:0]  sels  [4];
    logic [15:0] eas   [4];
    expPc = '{16'h4000, 16'h5000, 16'h4001, 16'h3011};
    expDp = '{3'd1, 3'd2, 3'd1, 3'd0};
    sels  = '{PC_SEL_CALL, PC_SEL_CALL, PC_SEL_RET, PC_SEL_RET};
    eas   = '{16'h4000, 16'h5000, 16'h0, 16'h0};
    applyStimulus(1'b1, PC_SEL_BUS, 1'b0, 1'b0, 16'h3010, 16'h0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, sels[i], 1'b0, 1'b0, 16'h0, eas[i]);
      checks++;
      if (pIf.reg_pc !== expPc[i] || pIf.ras_depth !== expDp[i])
        begin errors++; $display("[TB] FAIL call_ret_%0d actual=%h/%0d required=%h/%0d", i, pIf.reg_pc, pIf.ras_depth, expPc[i], expDp[i]); end
    end
    checks++;
    if ({pIf.ras_ovf, pIf.ras_unf} !== 2'b00) begin errors++; $display("[TB] FAIL call_ret_flags actual=%b required=00", {pIf.ras_ovf, pIf.ras_unf}); end
  endtask

  task automatic test_overflow();
    logic [15:0] retExp [4];
    retExp = '{16'h2301, 16'h2201, 16'h2101, 16'h2001};
    applyStimulus(1'b1, PC_SEL_BUS, 1'b0, 1'b0, 16'h1000, 16'h0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, PC_SEL_CALL, 1'b0, 1'b0, 16'h0, 16'h2000 + 16'(i) * 16'h0100);
      if (i == 3) begin
        checks++;
        if (pIf.ras_depth !== 3'd4 || pIf.ras_ovf !== 1'b0) begin errors++; $display("[TB] FAIL full_no_ovf actual=%0d/%b required=4/0", pIf.ras_depth, pIf.ras_ovf); end
      end
    end
    checks++;
    if (pIf.ras_depth !== 3'd4 || pIf.ras_ovf !== 1'b1 || pIf.reg_pc !== 16'h2400)
      begin errors++; $display("[TB] FAIL ovf_call actual=%0d/%b/%h required=4/1/2400", pIf.ras_depth, pIf.ras_ovf, pIf.reg_pc); end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, PC_SEL_RET, 1'b0, 1'b0, 16'h0, 16'h0);
      checks++;
      if (pIf.reg_pc !== retExp[i] || pIf.ras_depth !== 3'(3 - i))
        begin errors++; $display("[TB] FAIL ovf_ret_%0d actual=%h/%0d required=%h/%0d", i, pIf.reg_pc, pIf.ras_depth, retExp[i], 3 - i); end
    end
    applyStimulus(1'b1, PC_SEL_RET, 1'b0, 1'b0, 16'h0, 16'h0);
    checks++;
    if (pIf.reg_pc !== 16'h2001 || pIf.ras_unf !== 1'b1 || pIf.ras_ovf !== 1'b1 || pIf.ras_depth !== 3'd0)
      begin errors++; $display("[TB] FAIL unf_ret actual=%h/%b%b required=2001/11", pIf.reg_pc, pIf.ras_ovf, pIf.ras_unf); end
    applyStimulus(1'b0, PC_SEL_INC, 1'b0, 1'b1, 16'h0, 16'h0);
    checks++;
    if ({pIf.ras_ovf, pIf.ras_unf} !== 2'b00) begin errors++; $display("[TB] FAIL clr_err actual=%b required=00", {pIf.ras_ovf, pIf.ras_unf}); end
    applyStimulus(1'b1, PC_SEL_RET, 1'b0, 1'b1, 16'h0, 16'h0);
    checks++;
    if ({pIf.ras_ovf, pIf.ras_unf} !== 2'b01) begin errors++; $display("[TB] FAIL err_beats_clr actual=%b required=01", {pIf.ras_ovf, pIf.ras_unf}); end
    applyStimulus(1'b0, PC_SEL_INC, 1'b0, 1'b1, 16'h0, 16'h0);
  endtask

  task automatic test_stall();
    applyStimulus(1'b1, PC_SEL_BUS, 1'b0, 1'b0, 16'h0100, 16'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, PC_SEL_CALL, 1'b1, 1'b0, 16'h0, 16'h0800);
      checks++;
      if (pIf.reg_pc !== 16'h0100 || pIf.ras_depth !== 3'd0)
        begin errors++; $display("[TB] FAIL stall_%0d actual=%h/%0d required=0100/0", i, pIf.reg_pc, pIf.ras_depth); end
    end
    applyStimulus(1'b1, PC_SEL_CALL, 1'b0, 1'b0, 16'h0, 16'h0800);
    applyStimulus(1'b0, PC_SEL_CALL, 1'b0, 1'b0, 16'h0, 16'h0900);
    checks++;
    if (pIf.reg_pc !== 16'h0800 || pIf.ras_depth !== 3'd1)
      begin errors++; $display("[TB] FAIL stall_release actual=%h/%0d required=0800/1", pIf.reg_pc, pIf.ras_depth); end
    applyStimulus(1'b1, PC_SEL_RET, 1'b0, 1'b0, 16'h0, 16'h0);
    checks++;
    if (pIf.reg_pc !== 16'h0101 || pIf.ras_depth !== 3'd0)
      begin errors++; $display("[TB] FAIL stall_ret actual=%h/%0d required=0101/0", pIf.reg_pc, pIf.ras_depth); end
    applyStimulus(1'b1, PC_SEL_RET, 1'b1, 1'b0, 16'h0, 16'h0);
    checks++;
    if (pIf.ras_unf !== 1'b0) begin errors++; $display("[TB] FAIL stall_no_unf actual=%b required=0", pIf.ras_unf); end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, PC_SEL_CALL, 1'b0, 1'b0, 16'h0, 16'h6000 + 16'(i));
    applyStimulus(1'b1, PC_SEL_RET, 1'b0, 1'b0, 16'h0, 16'h0);
    checks++;
    if (pIf.ras_depth !== 3'd3 || pIf.ras_ovf !== 1'b1)
      begin errors++; $display("[TB] FAIL pre_reset actual=%0d/%b required=3/1", pIf.ras_depth, pIf.ras_ovf); end
    rst_n = 1'b0;
    applyStimulus(1'b1, PC_SEL_CALL, 1'b0, 1'b0, 16'h0, 16'h7777);
    rst_n = 1'b1;
    checks++;
    if (pIf.reg_pc !== RPC || pIf.ras_depth !== 3'd0 || {pIf.ras_ovf, pIf.ras_unf} !== 2'b00)
      begin errors++; $display("[TB] FAIL mid_reset actual=%h/%0d/%b%b required=3000/0/00", pIf.reg_pc, pIf.ras_depth, pIf.ras_ovf, pIf.ras_unf); end
`ifdef PC_UNIT_PREV_EN
    checks++;
    if (pIf.prev_pc !== RPC) begin errors++; $display("[TB] FAIL prev_reset actual=%h required=3000", pIf.prev_pc); end
`endif
    applyStimulus(1'b1, PC_SEL_RET, 1'b0, 1'b0, 16'h0, 16'h0);
    checks++;
    if (pIf.reg_pc !== RPC || pIf.ras_unf !== 1'b1)
      begin errors++; $display("[TB] FAIL post_reset_unf actual=%h/%b required=3000/1", pIf.reg_pc, pIf.ras_unf); end
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    tbDrvEn = 1'b0;
    tbDrvVal = 16'h0;
    pIf.gate_pc_en = 1'b0;
    pIf.gate_pc_minus_1_en = 1'b0;
    pIf.ld_pc = 1'b0;
    pIf.pc_sel = PC_SEL_INC;
    pIf.stall = 1'b0;
    pIf.clr_err = 1'b0;
    pIf.bus = '0;
    pIf.ea = '0;
    test_reset();
    test_inc();
    test_wrap();
    test_call_ret();
    test_overflow();
    test_stall();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
